// File: rtl/multiplier_pkg.sv
// multiplier_pkg: shared state encoding and default operand width for the shift-add multiplier.
package multiplier_pkg;
   localparam int DEFAULT_WIDTH = 8;
   typedef enum logic [1:0] {IDLE, WORKING, DONE} state_t;
endpackage

// File: rtl/multiplier_counter.sv
// multiplier_counter: iteration down-counter, preset to WIDTH-1, saturating at zero.
module multiplier_counter
   import multiplier_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic clock,
   input  logic reset,
   input  logic preset,
   input  logic decrement,
   output logic is_zero
);
   localparam int CW = $clog2(WIDTH);
   logic [CW-1:0] count;
   always_ff @(posedge clock or posedge reset) begin
      if (reset) count <= '0;
      else if (preset) count <= CW'(WIDTH - 1);
      else if (decrement && count != '0) count <= count - 1'b1;
   end
   assign is_zero = count == '0;
endmodule

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential shift-and-add multiplier, signed or unsigned,
// one partial product per cycle, WIDTH cycles per product with a valid/ack handshake.
module shift_add_multiplier
   import multiplier_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic               signed_mode,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   output logic               busy,
   output logic               result_valid,
   output logic [2*WIDTH-1:0] result,
   input  logic               result_ack
);
   state_t state, next_state;
   logic [WIDTH-1:0] a, q, m, mag_m, mag_q;
   logic [WIDTH:0] sum;
   logic [2*WIDTH-1:0] product;
   logic neg, accept, last;
   // Magnitudes are unsigned WIDTH-bit, so the most negative operand maps cleanly to 2^(WIDTH-1).
   assign mag_m = (signed_mode && multiplicand[WIDTH-1]) ? -multiplicand : multiplicand;
   assign mag_q = (signed_mode && multiplier[WIDTH-1]) ? -multiplier : multiplier;
   assign sum = {1'b0, a} + {1'b0, q[0] ? m : '0};
   always_comb begin
      accept = start && (state == IDLE || (state == DONE && result_ack));
      next_state = state;
      if (accept) next_state = WORKING;
      else if (state == WORKING && last) next_state = DONE;
      else if (state == DONE && result_ack) next_state = IDLE;
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else state <= next_state;
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         a   <= '0;
         q   <= '0;
         m   <= '0;
         neg <= 1'b0;
      end else if (accept) begin
         a   <= '0;
         q   <= mag_q;
         m   <= mag_m;
         neg <= signed_mode && (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
      end else if (state == WORKING) begin
         a <= sum[WIDTH:1];
         q <= {sum[0], q[WIDTH-1:1]};
      end
   end
   multiplier_counter #(.WIDTH(WIDTH)) counter (
      .clock(clock),
      .reset(reset),
      .preset(accept),
      .decrement(state == WORKING),
      .is_zero(last)
   );
   assign product = {a, q};
   assign busy = state != IDLE;
   assign result_valid = state == DONE;
   assign result = result_valid ? (neg ? -product : product) : '0;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: three lanes (WIDTH 2, 8, 16) checked every cycle against an arithmetic model,
// plus directed WIDTH=8 vectors with literal expectations.
module tb_shift_add_multiplier;
   localparam int WS [3] = '{2, 8, 16};
   logic clock = 1'b0;
   logic reset = 1'b1;
   logic [2:0] start = '0, sm = '0, ack = '0, busy, valid;
   logic [15:0] mc [3], mp [3];
   logic [31:0] res [3];
   int checks = 0, failures = 0;
   int mst [3], mcnt [3];
   longint mexp [3];

   always #5 clock = ~clock;

   for (genvar g = 0; g < 3; g++) begin : lane
      localparam int W = WS[g];
      logic [2*W-1:0] r;
      shift_add_multiplier #(.WIDTH(W)) dut (
         .clock(clock),
         .reset(reset),
         .start(start[g]),
         .signed_mode(sm[g]),
         .multiplicand(mc[g][W-1:0]),
         .multiplier(mp[g][W-1:0]),
         .busy(busy[g]),
         .result_valid(valid[g]),
         .result(r),
         .result_ack(ack[g])
      );
      assign res[g] = 32'(r);
   end

   function automatic longint ref_mul(input int w, input bit s, input longint a, input longint b);
      longint sa = a, sb = b, p;
      if (s && a[w-1]) sa = a - (longint'(1) << w);
      if (s && b[w-1]) sb = b - (longint'(1) << w);
      p = sa * sb;
      return p & ((longint'(1) << (2 * w)) - 1);
   endfunction

   task automatic chk(input string n, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
      end
   endtask

   // Model: 0 idle, 1 busy with mcnt edges left, 2 holding mexp.
   always @(posedge clock or posedge reset) begin
      for (int g = 0; g < 3; g++) begin
         if (reset) begin
            mst[g] <= 0;
            mcnt[g] <= 0;
            mexp[g] <= 0;
         end else if (start[g] && (mst[g] == 0 || (mst[g] == 2 && ack[g]))) begin
            mst[g] <= 1;
            mcnt[g] <= WS[g];
            mexp[g] <= ref_mul(WS[g], sm[g], longint'(mc[g]), longint'(mp[g]));
         end else if (mst[g] == 1) begin
            mcnt[g] <= mcnt[g] - 1;
            if (mcnt[g] == 1) mst[g] <= 2;
         end else if (mst[g] == 2 && ack[g]) mst[g] <= 0;
      end
   end

   always @(negedge clock) begin
      for (int g = 0; g < 3; g++) begin
         chk($sformatf("lane%0d busy", g), longint'(busy[g]), longint'(mst[g] != 0));
         chk($sformatf("lane%0d valid", g), longint'(valid[g]), longint'(mst[g] == 2));
         chk($sformatf("lane%0d result", g), longint'(res[g]), mst[g] == 2 ? mexp[g] : 0);
      end
   end

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic go1(input logic [7:0] a, input logic [7:0] b, input logic s);
      start[1] = 1'b1;
      sm[1] = s;
      mc[1] = 16'(a);
      mp[1] = 16'(b);
      tick;
      start[1] = 1'b0;
      sm[1] = ~s;
      mc[1] = 16'($urandom & 8'hFF);
      mp[1] = 16'($urandom & 8'hFF);
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!valid[1] && lat < 40) begin
         chk("busy while working", longint'(busy[1]), 1);
         tick;
         lat++;
      end
   endtask

   task automatic directed(input string n, input logic [7:0] a, input logic [7:0] b, input logic s,
                           input longint exp);
      int lat;
      go1(a, b, s);
      wait_valid(lat);
      chk({n, " latency"}, lat, 8);
      chk({n, " result"}, longint'(res[1]), exp);
      ack[1] = 1'b1;
      tick;
      ack[1] = 1'b0;
      chk({n, " idle after ack"}, longint'(busy[1]), 0);
   endtask

   initial begin
      int lat, n;
      int lt [3];
      for (int g = 0; g < 3; g++) begin
         mc[g] = '0;
         mp[g] = '0;
      end
      chk("model 13x11", ref_mul(8, 0, 13, 11), 'h008F);
      chk("model -3x5", ref_mul(8, 1, 'hFD, 5), 'hFFF1);
      chk("model -128x-128", ref_mul(8, 1, 'h80, 'h80), 'h4000);
      repeat (3) tick;
      chk("reset busy", longint'(busy[1]), 0);
      chk("reset valid", longint'(valid[1]), 0);
      chk("reset result", longint'(res[1]), 0);
      reset = 1'b0;
      go1(13, 11, 0);
      wait_valid(lat);
      chk("13x11 latency", lat, 8);
      chk("13x11 result", longint'(res[1]), 'h008F);
      for (int i = 0; i < 5; i++) begin
         start[1] = ~start[1];
         mc[1] = 16'($urandom & 8'hFF);
         mp[1] = 16'($urandom & 8'hFF);
         tick;
         chk("hold valid", longint'(valid[1]), 1);
         chk("hold result", longint'(res[1]), 'h008F);
      end
      start[1] = 1'b0;
      ack[1] = 1'b1;
      tick;
      ack[1] = 1'b0;
      chk("13x11 idle after ack", longint'(busy[1]), 0);
      directed("255x255", 255, 255, 0, 'hFE01);
      directed("-3x5", 8'hFD, 5, 1, 'hFFF1);
      directed("-128x-128", 8'h80, 8'h80, 1, 'h4000);
      directed("-128x0", 8'h80, 0, 1, 'h0000);
      go1(3, 4, 0);
      wait_valid(lat);
      chk("3x4 result", longint'(res[1]), 'h000C);
      ack[1] = 1'b1;
      go1(6, 7, 0);
      ack[1] = 1'b0;
      chk("b2b busy", longint'(busy[1]), 1);
      chk("b2b valid low", longint'(valid[1]), 0);
      for (int i = 1; i < 8; i++) begin
         ack[1] = i == 2;
         tick;
         chk("b2b not yet valid", longint'(valid[1]), 0);
      end
      ack[1] = 1'b0;
      tick;
      chk("b2b valid", longint'(valid[1]), 1);
      chk("b2b result", longint'(res[1]), 'h002A);
      ack[1] = 1'b1;
      tick;
      ack[1] = 1'b0;
      go1(200, 100, 0);
      repeat (3) tick;
      reset = 1'b1;
      #1;
      chk("midop reset busy", longint'(busy[1]), 0);
      chk("midop reset valid", longint'(valid[1]), 0);
      chk("midop reset result", longint'(res[1]), 0);
      tick;
      reset = 1'b0;
      directed("2x3", 2, 3, 0, 'h0006);
      for (int it = 0; it < 1000; it++) begin
         for (int g = 0; g < 3; g++) begin
            start[g] = 1'b1;
            sm[g] = 1'($urandom);
            mc[g] = 16'($urandom & ((32'd1 << WS[g]) - 1));
            mp[g] = 16'($urandom & ((32'd1 << WS[g]) - 1));
            lt[g] = 0;
         end
         tick;
         start = '0;
         n = 0;
         while (busy != '0 && n < 60) begin
            for (int g = 0; g < 3; g++) begin
               mc[g] = 16'($urandom & ((32'd1 << WS[g]) - 1));
               mp[g] = 16'($urandom & ((32'd1 << WS[g]) - 1));
            end
            tick;
            n++;
            for (int g = 0; g < 3; g++) begin
               if (valid[g] && lt[g] == 0) lt[g] = n;
               ack[g] = valid[g];
            end
         end
         ack = '0;
         for (int g = 0; g < 3; g++) chk($sformatf("lane%0d random latency", g), lt[g], WS[g]);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
